pss_peak_detector: RTL and testbench

//   Sits directly downstream of the PSS correlator and consumes its magnitude stream.

---
 rtl/pss_peak_detector_if.sv | 10 +
 rtl/pss_peak_detector.sv | 136 +++++++++++++
 tb/tb_pss_peak_detector.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pss_peak_detector_if.sv
// rtl/pss_peak_detector_if.sv - magnitude sample stream from the PSS correlator
interface pss_peak_detector_if #(
    parameter int DW = 24
);
    logic [DW-1:0] tdata;
    logic          tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/pss_peak_detector.sv
// rtl/pss_peak_detector.sv - moving-average threshold PSS peak detector with windowed max and blanking
module pss_peak_detector #(
    parameter int IN_DW           = 24,
    parameter int WINDOW_LEN      = 64,
    parameter int DETECTION_SHIFT = 4,
    parameter int PEAK_WINDOW     = 8,
    parameter int BLANK_LEN       = 256,
    parameter int SAMPLE_CNT_DW   = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    pss_peak_detector_if.slave       s_axis_in,
    output logic                     peak_detected_o,
    output logic [IN_DW-1:0]         peak_value_o,
    output logic [SAMPLE_CNT_DW-1:0] peak_index_o,
    output logic [IN_DW-1:0]         avg_o
);
    localparam int LOG2W  = $clog2(WINDOW_LEN);
    localparam int SUM_W  = IN_DW + LOG2W;
    localparam int THR_W  = IN_DW + DETECTION_SHIFT;
    localparam int FILL_W = LOG2W + 1;
    localparam int PCNT_W = $clog2(PEAK_WINDOW + 1);
    localparam int BCNT_W = $clog2(BLANK_LEN + 1);

    typedef enum logic [1:0] {SEARCH, TRACK, REPORT, BLANK} state_t;

    state_t                   state;
    logic [IN_DW-1:0]         hist [WINDOW_LEN];
    logic [LOG2W-1:0]         wr_ptr;
    logic [SUM_W-1:0]         sum;
    logic [FILL_W-1:0]        fill_cnt;
    logic [SAMPLE_CNT_DW-1:0] sample_idx;
    logic [IN_DW-1:0]         max_q;
    logic [SAMPLE_CNT_DW-1:0] idx_q;
    logic [PCNT_W-1:0]        pcnt;
    logic [BCNT_W-1:0]        bcnt;

    logic [IN_DW-1:0]         in_data;
    logic                     in_valid;
    logic [IN_DW-1:0]         oldest;
    logic [SUM_W-1:0]         sum_next;
    logic [IN_DW-1:0]         avg_prev;
    logic [IN_DW-1:0]         avg_next;
    logic [THR_W-1:0]         threshold;
    logic                     candidate;
    logic                     track_upd;
    logic [IN_DW-1:0]         max_nxt;
    logic [SAMPLE_CNT_DW-1:0] idx_nxt;

    assign in_data   = s_axis_in.tdata;
    assign in_valid  = s_axis_in.tvalid;
    assign oldest    = hist[wr_ptr];
    // oldest is always part of sum, so the subtraction cannot underflow
    assign sum_next  = sum + SUM_W'(in_data) - SUM_W'(oldest);
    assign avg_prev  = sum[LOG2W +: IN_DW];
    assign avg_next  = sum_next[LOG2W +: IN_DW];
    assign threshold = THR_W'(avg_prev) << DETECTION_SHIFT;
    assign candidate = (fill_cnt == FILL_W'(WINDOW_LEN)) && (THR_W'(in_data) > threshold);
    // strict compare keeps the earliest of equal maxima
    assign track_upd = in_data > max_q;
    assign max_nxt   = track_upd ? in_data : max_q;
    assign idx_nxt   = track_upd ? sample_idx : idx_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < WINDOW_LEN; i++) hist[i] <= '0;
            wr_ptr          <= '0;
            sum             <= '0;
            fill_cnt        <= '0;
            sample_idx      <= '0;
            state           <= SEARCH;
            max_q           <= '0;
            idx_q           <= '0;
            pcnt            <= '0;
            bcnt            <= '0;
            peak_detected_o <= 1'b0;
            peak_value_o    <= '0;
            peak_index_o    <= '0;
            avg_o           <= '0;
        end else begin
            peak_detected_o <= 1'b0;

            if (in_valid) begin
                hist[wr_ptr] <= in_data;
                wr_ptr       <= wr_ptr + LOG2W'(1);
                sum          <= sum_next;
                avg_o        <= avg_next;
                sample_idx   <= sample_idx + SAMPLE_CNT_DW'(1);
                if (fill_cnt != FILL_W'(WINDOW_LEN)) fill_cnt <= fill_cnt + FILL_W'(1);
            end

            case (state)
                SEARCH: begin
                    if (in_valid && candidate) begin
                        max_q <= in_data;
                        idx_q <= sample_idx;
                        pcnt  <= PCNT_W'(1);
                        if (PEAK_WINDOW == 1) begin
                            state           <= REPORT;
                            peak_detected_o <= 1'b1;
                            peak_value_o    <= in_data;
                            peak_index_o    <= sample_idx;
                        end else begin
                            state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (in_valid) begin
                        max_q <= max_nxt;
                        idx_q <= idx_nxt;
                        pcnt  <= pcnt + PCNT_W'(1);
                        if (pcnt == PCNT_W'(PEAK_WINDOW - 1)) begin
                            state           <= REPORT;
                            peak_detected_o <= 1'b1;
                            peak_value_o    <= max_nxt;
                            peak_index_o    <= idx_nxt;
                        end
                    end
                end
                REPORT: begin
                    // a sample arriving during the report is the first blanked one
                    bcnt  <= in_valid ? BCNT_W'(1) : BCNT_W'(0);
                    state <= (in_valid && BLANK_LEN == 1) ? SEARCH : BLANK;
                end
                BLANK: begin
                    if (in_valid) begin
                        if (bcnt == BCNT_W'(BLANK_LEN - 1)) state <= SEARCH;
                        else                                bcnt  <= bcnt + BCNT_W'(1);
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_pss_peak_detector.sv
// tb/tb_pss_peak_detector.sv - scoreboard bench for pss_peak_detector with directed spike patterns
module tb_pss_peak_detector;
    localparam int IN_DW = 24;
    localparam int CW    = 32;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             peak_detected;
    logic [IN_DW-1:0] peak_value;
    logic [CW-1:0]    peak_index;
    logic [IN_DW-1:0] avg;

    pss_peak_detector_if #(.DW(IN_DW)) s_axis_in ();

    pss_peak_detector dut (
        .clk_i           (clk),
        .reset_ni        (resetn),
        .s_axis_in       (s_axis_in),
        .peak_detected_o (peak_detected),
        .peak_value_o    (peak_value),
        .peak_index_o    (peak_index),
        .avg_o           (avg)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint value;
        longint index;
        longint last;
    } exp_t;

    exp_t   exp_q[$];
    int     spikes[int];
    int     n_vec = 0;
    int     n_bad = 0;
    longint cap_cnt = 0;
    longint last_cap = -1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sval(input int i);
        return spikes.exists(i) ? spikes[i] : 100;
    endfunction

    task automatic push_exp(input longint v, input longint idx, input longint last);
        exp_t e;
        e.value = v;
        e.index = idx;
        e.last  = last;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // index of the most recent valid sample the DUT has captured
    always @(posedge clk) begin
        if (!resetn) begin
            cap_cnt  <= 0;
            last_cap <= -1;
        end else if (s_axis_in.tvalid === 1'b1) begin
            last_cap <= cap_cnt;
            cap_cnt  <= cap_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (peak_detected === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", longint'(peak_index), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("peak_value", longint'(peak_value), e.value);
                check("peak_index", longint'(peak_index), e.index);
                check("pulse_after_sample", last_cap, e.last);
            end
        end
    end

    task automatic do_reset(input int cycles, input bit check_outs);
        resetn = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            s_axis_in.tvalid = 1'($urandom_range(1));
            s_axis_in.tdata  = IN_DW'($urandom);
            tick();
            if (check_outs) begin
                check("rst_pulse", longint'(peak_detected), 0);
                check("rst_value", longint'(peak_value), 0);
                check("rst_index", longint'(peak_index), 0);
                check("rst_avg",   longint'(avg), 0);
            end
        end
        s_axis_in.tvalid = 1'b0;
        s_axis_in.tdata  = '0;
        resetn = 1'b1;
    endtask

    // drives samples start..start+n-1; gap_pct percent of cycles are idle
    task automatic drive_stream(input int start, input int n, input int gap_pct);
        int i;
        i = start;
        while (i < start + n) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_axis_in.tvalid = 1'b0;
                s_axis_in.tdata  = IN_DW'($urandom);
            end else begin
                s_axis_in.tvalid = 1'b1;
                s_axis_in.tdata  = IN_DW'(sval(i));
                i++;
            end
            tick();
        end
        s_axis_in.tvalid = 1'b0;
        s_axis_in.tdata  = '0;
    endtask

    task automatic end_test(input string name);
        s_axis_in.tvalid = 1'b0;
        repeat (4) tick();
        check({name, "_pending"}, longint'(exp_q.size()), 0);
        exp_q.delete();
        spikes.delete();
    endtask

    initial begin
        s_axis_in.tvalid = 1'b0;
        s_axis_in.tdata  = '0;

        do_reset(5, 1'b1);

        // constant input: partial averages during fill, then steady 100
        do_reset(2, 1'b0);
        drive_stream(0, 1, 0);
        check("avg_after_1", longint'(avg), 1);
        drive_stream(1, 31, 0);
        check("avg_after_32", longint'(avg), 50);
        drive_stream(32, 480, 0);
        check("avg_after_512", longint'(avg), 100);
        end_test("const");

        // 1000 and exactly-threshold 1600 are not above 100<<4
        do_reset(2, 1'b0);
        spikes[200] = 1000;
        drive_stream(0, 300, 0);
        end_test("below_thr");
        do_reset(2, 1'b0);
        spikes[200] = 1600;
        drive_stream(0, 300, 0);
        end_test("equal_thr");

        do_reset(2, 1'b0);
        spikes[200] = 1700;
        push_exp(1700, 200, 207);
        drive_stream(0, 300, 0);
        end_test("single");

        do_reset(2, 1'b0);
        spikes[200] = 1700; spikes[203] = 2000; spikes[205] = 2000;
        push_exp(2000, 203, 207);
        drive_stream(0, 300, 0);
        end_test("tie");

        do_reset(2, 1'b0);
        spikes[200] = 1800; spikes[300] = 1800; spikes[600] = 1800;
        push_exp(1800, 200, 207);
        push_exp(1800, 600, 607);
        drive_stream(0, 700, 0);
        end_test("blank");

        // last blanked sample is 463, first searched sample is 464
        do_reset(2, 1'b0);
        spikes[200] = 1800; spikes[463] = 1800; spikes[464] = 2500;
        push_exp(1800, 200, 207);
        push_exp(2500, 464, 471);
        drive_stream(0, 520, 0);
        end_test("blank_edge");

        do_reset(2, 1'b0);
        spikes[10] = 1800;
        drive_stream(0, 120, 0);
        end_test("unfilled");

        do_reset(2, 1'b0);
        spikes[200] = 1700;
        push_exp(1700, 200, 207);
        drive_stream(0, 300, 30);
        end_test("gaps");

        // reset while tracking drops the report and restarts the index
        do_reset(2, 1'b0);
        spikes[200] = 1700;
        drive_stream(0, 203, 0);
        do_reset(3, 1'b0);
        tick();
        check("midrst_value", longint'(peak_value), 0);
        check("midrst_avg", longint'(avg), 0);
        spikes[200] = 1700;
        push_exp(1700, 200, 207);
        drive_stream(0, 300, 0);
        end_test("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
